// File: rtl/regfile_pkg.sv
// Shared constants, clear-engine state encoding and address-width helper
// for the multi-port integer register file.
package regfile_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_DEPTH = 32;

  typedef enum logic [0:0] {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // A single-entry array still needs one address bit.
  function automatic int rf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/execute-side bus of the register file: read ports, write port,
// re-init request, ready status and debug read.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = 2
);

  localparam int AW = rf_aw(DEPTH);

  logic                     rd_en;
  logic [NUM_RD*AW-1:0]     rs_addr;
  logic [NUM_RD*XLEN-1:0]   rd_data;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [XLEN-1:0]          wr_data;
  logic                     init_start;
  logic                     ready;
  logic [AW-1:0]            dbg_addr;
  logic [XLEN-1:0]          dbg_data;

  modport master (
    output rd_en, rs_addr, wr_en, wr_addr, wr_data, init_start, dbg_addr,
    input  rd_data, ready, dbg_data
  );

  modport slave (
    input  rd_en, rs_addr, wr_en, wr_addr, wr_data, init_start, dbg_addr,
    output rd_data, ready, dbg_data
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every entry once after reset or on request,
// then reports the array ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_INIT   | clearing mem[cnt] each edge; user reads/writes blocked
//   S_READY  | array initialised; init_start restarts the sweep
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  localparam int AW   = rf_aw(DEPTH)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          init_start,
  output logic          ready,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr
);

  localparam logic [0:0]    S_INIT  = RF_INIT;
  localparam logic [0:0]    S_READY = RF_READY;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [0:0]    state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == S_INIT) begin
      if (cnt == LAST) begin
        state <= S_READY;
        ready <= 1'b1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (init_start) begin
      state <= S_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end
  end

  assign clear_we   = (state == S_INIT);
  assign clear_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// RV32 integer register file: flop array, NUM_RD registered read ports with
// optional write bypass, hardwired x0 and a sequential clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clock,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int AW = rf_aw(DEPTH);

  logic            ready;
  logic            clear_we;
  logic [AW-1:0]   clear_addr;
  logic            user_we;
  logic [XLEN-1:0] mem [DEPTH];

  regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear (
    .clock      (clock),
    .rst_n      (rst_n),
    .init_start (bus.init_start),
    .ready      (ready),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  assign bus.ready = ready;

  // True for entries that actually hold storage (in range, not a wired x0).
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // A write arriving together with a re-init request is dropped.
  assign user_we = ready && bus.wr_en && !bus.init_start && addr_live(bus.wr_addr);

  always_ff @(posedge clock) begin
    if (clear_we) begin
      mem[clear_addr] <= '0;
    end else if (user_we) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] data_q;

    assign addr = bus.rs_addr[k*AW +: AW];

    always_comb begin
      value = '0;
      if (addr_live(addr)) begin
        if ((BYPASS != 0) && user_we && (bus.wr_addr == addr)) begin
          value = bus.wr_data;
        end else begin
          value = mem[addr];
        end
      end
    end

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else if (ready && bus.rd_en) begin
        data_q <= value;
      end
    end

    assign bus.rd_data[k*XLEN +: XLEN] = data_q;
  end

  always_comb begin
    bus.dbg_data = '0;
    if (addr_live(bus.dbg_addr)) begin
      bus.dbg_data = mem[bus.dbg_addr];
    end
  end

endmodule
